mem_bus_ctrl: RTL

// - Memory-side bus controller and 256x8 RAM. Sits directly downstream of the CPU's addr_bus/data_bus.
// - Serves CPU instruction fetches, LOAD reads and STORE writes over a four-phase req/ready handshake.
// - Adds programmable wait states and drives the shared tri-state data_bus only during read data phase.

---
 rtl/mem_bus_ctrl_if.sv | 30 +++
 rtl/mem_bus_ctrl.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/mem_bus_ctrl_if.sv
// CPU-side memory bus: level request handshake, access address and the shared data bus.
interface mem_bus_ctrl_if #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 8
);
  logic [AW-1:0] addr_bus;
  logic          rd_req;
  logic          wr_req;
  logic          ready;
  logic          busy;
  logic          err;
  logic [DW-1:0] cpu_dout;
  logic          cpu_oe;
  logic [DW-1:0] mem_dout;
  logic          mem_oe;
  wire  [DW-1:0] data_bus;

  // Single resolution point; the memory side owns the bus only during a read completion.
  assign data_bus = mem_oe ? mem_dout : (cpu_oe ? cpu_dout : {DW{1'bz}});

  modport master (
    output addr_bus, rd_req, wr_req, cpu_dout, cpu_oe,
    input  ready, busy, err, data_bus
  );

  modport slave (
    input  addr_bus, rd_req, wr_req, data_bus,
    output ready, busy, err, mem_dout, mem_oe
  );
endinterface

// File: rtl/mem_bus_ctrl.sv
// Memory-side bus controller with 2**AW x DW RAM, programmable wait states and tri-state read return.
// Optional write protection of the program area is enabled by defining MEM_WP_EN.
module mem_bus_ctrl #(
  parameter int unsigned   AW     = 8,
  parameter int unsigned   DW     = 8,
  parameter int unsigned   WAIT   = 2,
  parameter logic [AW-1:0] WP_TOP = AW'(8'h40)
) (
  input  logic          clk,
  input  logic          rst,
  mem_bus_ctrl_if.slave bus,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [DW-1:0] load_data
);
  localparam int unsigned DEPTH = 2 ** AW;
  localparam int unsigned CW    = 4;
`ifdef MEM_WP_EN
  localparam bit WP_ON = 1'b1;
`else
  localparam bit WP_ON = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_DONE} state_t;

  state_t        state;
  logic [CW-1:0] wcnt;
  logic          rd_q;
  logic          wr_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata;
  logic          dir_wr;
  logic          ready;
  logic          busy;
  logic          err;
  logic          drive;
  logic [DW-1:0] mem [DEPTH];

  logic          wp_hit_c;
  logic          mem_we_c;
  logic [AW-1:0] mem_wa_c;
  logic [DW-1:0] mem_wd_c;

  assign wp_hit_c = WP_ON && dir_wr && (addr_q < WP_TOP);

  // Request levels are registered once before the FSM acts on them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q <= 1'b0;
      wr_q <= 1'b0;
    end else begin
      rd_q <= bus.rd_req;
      wr_q <= bus.wr_req;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      wcnt    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata   <= '0;
      dir_wr  <= 1'b0;
      ready   <= 1'b0;
      busy    <= 1'b0;
      err     <= 1'b0;
      drive   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!load_en) begin
            if (rd_q ^ wr_q) begin
              addr_q  <= bus.addr_bus;
              wdata_q <= bus.data_bus;
              dir_wr  <= wr_q;
              wcnt    <= CW'(WAIT);
              busy    <= 1'b1;
              state   <= (WAIT > 0) ? S_WAIT : S_ACCESS;
            end else if (rd_q && wr_q) begin
              // Collision: no memory access, report it through the normal completion.
              dir_wr <= 1'b1;
              busy   <= 1'b1;
              ready  <= 1'b1;
              err    <= 1'b1;
              state  <= S_DONE;
            end
          end
        end
        S_WAIT: begin
          wcnt <= wcnt - CW'(1);
          if (wcnt == CW'(1)) state <= S_ACCESS;
        end
        S_ACCESS: begin
          if (!dir_wr) rdata <= mem[addr_q];
          ready <= 1'b1;
          err   <= wp_hit_c;
          drive <= !dir_wr;
          state <= S_DONE;
        end
        S_DONE: begin
          if (!rd_q && !wr_q) begin
            ready <= 1'b0;
            err   <= 1'b0;
            busy  <= 1'b0;
            drive <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Single RAM write port shared by preload (IDLE only) and committed bus writes.
  always_comb begin
    mem_we_c = 1'b0;
    mem_wa_c = addr_q;
    mem_wd_c = wdata_q;
    if (!rst) begin
      if (state == S_IDLE && load_en) begin
        mem_we_c = 1'b1;
        mem_wa_c = load_addr;
        mem_wd_c = load_data;
      end else if (state == S_ACCESS && dir_wr && !wp_hit_c) begin
        mem_we_c = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we_c) mem[mem_wa_c] <= mem_wd_c;
  end

  assign bus.ready    = ready;
  assign bus.busy     = busy;
  assign bus.err      = err;
  assign bus.mem_dout = rdata;
  assign bus.mem_oe   = drive;
endmodule
